// File: rtl/regwrite_scoreboard.sv
// Per-register in-flight write scoreboard with a flush drain window.
// Optional SCOREBOARD_RETIRE_BYPASS_EN lets a same-cycle retire clear a source hazard.
module regwrite_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_RegWrt,
  input  logic [4:0]  issue_Rd,
  input  logic [4:0]  issue_Rn,
  input  logic [4:0]  issue_Rm,
  input  logic        Rn_used,
  input  logic        Rm_used,
  input  logic        retire_RegWrt,
  input  logic [4:0]  retire_Rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] pending,
  output logic        underflow_err
);

  localparam logic [4:0] Xzr      = 5'd31;
  localparam logic [2:0] MaxCnt   = 3'd4;
  localparam logic [2:0] DrainLen = 3'd4;

  typedef enum logic {StRun, StDrain} state_e;

  state_e     state_q, state_d;
  logic [2:0] drain_q, drain_d;
  logic [2:0] cnt_q [32];
  logic [2:0] cnt_d [32];
  logic       underflow_q, underflow_d;

  logic       run_ok;
  logic       ret_dec;
  logic       ret_under;
  logic       inc;
  logic       sat;
  logic       haz_rn, haz_rm;
  logic [2:0] rn_cnt, rm_cnt;

  // Flush outranks any same-cycle issue or retire.
  assign run_ok    = (state_q == StRun) && !flush;
  assign ret_dec   = run_ok && retire_RegWrt && (retire_Rd != Xzr) && (cnt_q[retire_Rd] != 3'd0);
  assign ret_under = run_ok && retire_RegWrt && (retire_Rd != Xzr) && (cnt_q[retire_Rd] == 3'd0);

`ifdef SCOREBOARD_RETIRE_BYPASS_EN
  assign rn_cnt = (ret_dec && (retire_Rd == issue_Rn)) ? cnt_q[issue_Rn] - 3'd1 : cnt_q[issue_Rn];
  assign rm_cnt = (ret_dec && (retire_Rd == issue_Rm)) ? cnt_q[issue_Rm] - 3'd1 : cnt_q[issue_Rm];
`else
  assign rn_cnt = cnt_q[issue_Rn];
  assign rm_cnt = cnt_q[issue_Rm];
`endif

  assign haz_rn = Rn_used && (issue_Rn != Xzr) && (rn_cnt != 3'd0);
  assign haz_rm = Rm_used && (issue_Rm != Xzr) && (rm_cnt != 3'd0);
  assign sat    = issue_RegWrt && (issue_Rd != Xzr) && (cnt_q[issue_Rd] == MaxCnt);

  assign stall = (state_q == StDrain) || (issue_valid && (haz_rn || haz_rm || sat));
  assign inc   = run_ok && issue_valid && !stall && issue_RegWrt && (issue_Rd != Xzr);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i < 31) begin
        // Increment and decrement of the same register cancel out.
        if (inc && (issue_Rd == 5'(i))) cnt_d[i] = cnt_d[i] + 3'd1;
        if (ret_dec && (retire_Rd == 5'(i))) cnt_d[i] = cnt_d[i] - 3'd1;
      end
      if (flush || (i == 31)) cnt_d[i] = 3'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    underflow_d = underflow_q | ret_under;
    unique case (state_q)
      StRun: begin
        if (flush) begin
          state_d = StDrain;
          drain_d = DrainLen;
        end
      end
      StDrain: begin
        if (flush) begin
          drain_d = DrainLen;
        end else begin
          drain_d = drain_q - 3'd1;
          if (drain_q <= 3'd1) begin
            drain_d = 3'd0;
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d = StRun;
        drain_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      drain_q     <= 3'd0;
      underflow_q <= 1'b0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= 3'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      underflow_q <= underflow_d;
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    pending = 32'd0;
    for (int i = 0; i < 31; i++) pending[i] = (cnt_q[i] != 3'd0);
  end

  assign underflow_err = underflow_q;

endmodule
